// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder types: path metric width, state count and state index type.
package viterbi_pkg;

  localparam int PM_WIDTH   = 4;
  localparam int NUM_STATES = 4;

  typedef logic [1:0]          state_idx_t;
  typedef logic [PM_WIDTH-1:0] pm_t;

endpackage

// File: rtl/pm_cmp2.sv
// Combinational two-input compare-select: passes through the smaller metric and its state index.
module pm_cmp2
  import viterbi_pkg::*;
#(
  parameter int W = PM_WIDTH
) (
  input  logic [W-1:0] pm_a,
  input  state_idx_t   idx_a,
  input  logic [W-1:0] pm_b,
  input  state_idx_t   idx_b,
  output logic [W-1:0] min_pm,
  output state_idx_t   min_idx
);

  logic b_wins;

  // On equal metrics the lower state index is kept, whichever side carries it.
  assign b_wins  = (pm_b < pm_a) || ((pm_b == pm_a) && (idx_b < idx_a));
  assign min_pm  = b_wins ? pm_b  : pm_a;
  assign min_idx = b_wins ? idx_b : idx_a;

endmodule

// File: rtl/pm_min_selector.sv
// Best-state selector: two-level compare tree over four path metrics, registered with valid.
module pm_min_selector
  import viterbi_pkg::*;
#(
  parameter int PM_WIDTH = viterbi_pkg::PM_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [PM_WIDTH-1:0] pm0,
  input  logic [PM_WIDTH-1:0] pm1,
  input  logic [PM_WIDTH-1:0] pm2,
  input  logic [PM_WIDTH-1:0] pm3,
  output logic                d0,
  output logic                d1,
  output logic [PM_WIDTH-1:0] min_pm,
  output logic                out_valid
);

  logic [PM_WIDTH-1:0] pm_in [NUM_STATES];
  logic [PM_WIDTH-1:0] l1_pm [2];
  state_idx_t          l1_idx [2];
  logic [PM_WIDTH-1:0] best_pm;
  state_idx_t          best_idx;

  assign pm_in[0] = pm0;
  assign pm_in[1] = pm1;
  assign pm_in[2] = pm2;
  assign pm_in[3] = pm3;

  // Level 1 pairs states {0,1} and {2,3}.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_level1
      pm_cmp2 #(.W(PM_WIDTH)) u_cmp (
        .pm_a   (pm_in[2*gi]),
        .idx_a  (state_idx_t'(2*gi)),
        .pm_b   (pm_in[2*gi+1]),
        .idx_b  (state_idx_t'(2*gi+1)),
        .min_pm (l1_pm[gi]),
        .min_idx(l1_idx[gi])
      );
    end
  endgenerate

  pm_cmp2 #(.W(PM_WIDTH)) u_level2 (
    .pm_a   (l1_pm[0]),
    .idx_a  (l1_idx[0]),
    .pm_b   (l1_pm[1]),
    .idx_b  (l1_idx[1]),
    .min_pm (best_pm),
    .min_idx(best_idx)
  );

  state_idx_t          idx_q, idx_d;
  logic [PM_WIDTH-1:0] min_pm_q, min_pm_d;
  logic                out_valid_q, out_valid_d;

  // Result registers only load on a valid input so the last winner is held through gaps.
  always_comb begin
    idx_d       = idx_q;
    min_pm_d    = min_pm_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      idx_d    = best_idx;
      min_pm_d = best_pm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      min_pm_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      min_pm_q    <= min_pm_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign d0        = idx_q[0];
  assign d1        = idx_q[1];
  assign min_pm    = min_pm_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pm_min_selector.sv
// Scoreboard bench for pm_min_selector: directed corner vectors plus a random sweep.
module tb_pm_min_selector;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] pm0, pm1, pm2, pm3;
  logic         d0, d1;
  logic [W-1:0] min_pm;
  logic         out_valid;

  typedef struct packed {
    logic [1:0]   idx;
    logic [W-1:0] val;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [1:0]   held_idx = 2'd0;
  logic [W-1:0] held_min = '0;

  pm_min_selector #(.PM_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .pm0      (pm0),
    .pm1      (pm1),
    .pm2      (pm2),
    .pm3      (pm3),
    .d0       (d0),
    .d1       (d1),
    .min_pm   (min_pm),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: scan states in ascending order, replacing only on a strictly smaller metric.
  function automatic exp_t ref_min(input int a, input int b, input int c, input int d);
    int   m[4];
    exp_t r;
    m[0] = a; m[1] = b; m[2] = c; m[3] = d;
    r.idx = 2'd0;
    r.val = W'(m[0]);
    for (int i = 1; i < 4; i++) begin
      if (m[i] < int'(r.val)) begin
        r.idx = 2'(i);
        r.val = W'(m[i]);
      end
    end
    return r;
  endfunction

  task automatic send(input int a, input int b, input int c, input int d);
    @(negedge clk);
    in_valid = 1'b1;
    pm0 = W'(a); pm1 = W'(b); pm2 = W'(c); pm3 = W'(d);
    exp_q.push_back(ref_min(a, b, c, d));
    $display("send pm=(%0d,%0d,%0d,%0d)", a, b, c, d);
  endtask

  task automatic idle(input int a, input int b, input int c, input int d);
    @(negedge clk);
    in_valid = 1'b0;
    pm0 = W'(a); pm1 = W'(b); pm2 = W'(c); pm3 = W'(d);
    $display("idle pm=(%0d,%0d,%0d,%0d)", a, b, c, d);
  endtask

  task automatic check_reset(input string name);
    checks++;
    if ({d1, d0} !== 2'b00 || min_pm !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: got d1d0=%b min_pm=%0d out_valid=%b, want d1d0=00 min_pm=0 out_valid=0",
               name, {d1, d0}, min_pm, out_valid);
    end else begin
      $display("check %s ok", name);
    end
  endtask

  // Monitor: pops one expectation per valid output; checks hold behaviour on idle cycles.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got out_valid=1 d1d0=%b min_pm=%0d, want out_valid=0",
                   {d1, d0}, min_pm);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          held_idx = e.idx;
          held_min = e.val;
          if ({d1, d0} !== e.idx || min_pm !== e.val) begin
            errors++;
            $display("FAIL result: got d1d0=%b min_pm=%0d, want d1d0=%b min_pm=%0d",
                     {d1, d0}, min_pm, e.idx, e.val);
          end else begin
            $display("result d1d0=%b min_pm=%0d ok", {d1, d0}, min_pm);
          end
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || {d1, d0} !== held_idx || min_pm !== held_min) begin
          errors++;
          $display("FAIL hold: got out_valid=%b d1d0=%b min_pm=%0d, want out_valid=0 d1d0=%b min_pm=%0d",
                   out_valid, {d1, d0}, min_pm, held_idx, held_min);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    pm0 = '0; pm1 = '0; pm2 = '0; pm3 = '0;
    repeat (2) @(negedge clk);
    check_reset("reset_initial");
    #2 rst = 1'b0;

    // Load a nonzero result so the asynchronous clear is observable.
    send(4, 3, 2, 1);
    idle(0, 0, 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset("reset_async");
    exp_q.delete();
    held_idx = 2'd0;
    held_min = '0;
    @(negedge clk);
    check_reset("reset_held");
    #2 rst = 1'b0;

    send(0, 0, 0, 0);
    send(1, 2, 3, 4);
    send(4, 3, 2, 1);
    send(2, 1, 4, 3);
    send(7, 5, 1, 2);
    send(1, 6, 3, 4);
    send(5, 3, 3, 9);
    send(8, 8, 2, 2);
    send(15, 15, 15, 15);
    send(15, 15, 15, 14);
    send(4, 3, 2, 1);
    idle(0, 9, 9, 9);
    idle(0, 9, 9, 9);
    idle(3, 3, 3, 3);

    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 7) == 0)
        idle($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    end
    idle(0, 0, 0, 0);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
